// File: rtl/kw_stream_pkg.sv
// Shared definitions for the KW credit-based stream link (transmitter, receiver FIFO and
// later credit-aware blocks).
package kw_stream_pkg;

    localparam int ERR_PULSE  = 0;
    localparam int ERR_STICKY = 1;

    // Bits needed to hold a credit count from 0 up to n inclusive.
    function automatic int credit_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/kw_credit_counter.sv
// Credit counter: starts full, decrements on take, increments on give, saturates at CREDITS and
// flags a give that would overflow.
module kw_credit_counter
    import kw_stream_pkg::*;
#(
    parameter int CREDITS  = 32,
    parameter int ERR_MODE = ERR_STICKY,
    localparam int CW      = credit_width(CREDITS)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          take,
    input  logic          give,
    output logic [CW-1:0] count,
    output logic          nonzero,
    output logic          err
);

    localparam logic [CW-1:0] FULL = CW'(CREDITS);

    logic overflow;

    assign nonzero  = (count != '0);
    // A lone give at full means the receiver returned more credits than it was ever sent.
    assign overflow = give && !take && (count == FULL);

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= FULL;
            err   <= 1'b0;
        end else begin
            if (take && !give) begin
                count <= count - CW'(1);
            end else if (give && !take && !overflow) begin
                count <= count + CW'(1);
            end
            if (ERR_MODE == ERR_STICKY) begin
                err <= err | overflow;
            end else begin
                err <= overflow;
            end
        end
    end

endmodule

// File: rtl/kw_stream_credit_tx.sv
// Transmit end of the credit-based stream link: turns a ready/valid stream into registered
// valid-only beats, pacing them by the credits the remote receiver FIFO returns.
module kw_stream_credit_tx
    import kw_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int CREDITS    = 32,
    parameter int ERR_MODE   = ERR_STICKY,
    localparam int CW        = credit_width(CREDITS)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_valid,
    output logic                  i_ready,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    input  logic                  credit_ret,
    output logic [CW-1:0]         credit_count,
    output logic                  err
);

    // Upstream handshake: a word transfers on a rising edge where i_valid && i_ready; i_ready
    // depends only on the registered credit count (and reset), never on i_valid or credit_ret.
    logic nonzero;
    logic accept;

    assign i_ready = nonzero && !reset;
    assign accept  = i_valid && i_ready;

    kw_credit_counter #(
        .CREDITS  (CREDITS),
        .ERR_MODE (ERR_MODE)
    ) u_credits (
        .clock   (clock),
        .reset   (reset),
        .take    (accept),
        .give    (credit_ret),
        .count   (credit_count),
        .nonzero (nonzero),
        .err     (err)
    );

    // o_data only loads on accept so it stays quiet between beats.
    always_ff @(posedge clock) begin
        if (reset) begin
            o_valid <= 1'b0;
            o_data  <= '0;
        end else begin
            o_valid <= accept;
            if (accept) begin
                o_data <= i_data;
            end
        end
    end

endmodule

// File: tb/tb_kw_stream_credit_tx.sv
// Bench for kw_stream_credit_tx: sticky and pulse error variants driven in lockstep, checked
// against a credit/queue reference model.
module tb_kw_stream_credit_tx;

    localparam int W = 16;
    localparam int C = 32;

    logic          clock = 1'b0;
    logic          reset;
    logic          i_valid;
    logic [W-1:0]  i_data;
    logic          credit_ret;

    logic          rdy_s, rdy_p, ov_s, ov_p, err_s, err_p;
    logic [W-1:0]  od_s, od_p;
    logic [5:0]    cnt_s, cnt_p;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int            m_credits = C;
    logic          m_valid   = 1'b0;
    logic [W-1:0]  m_data    = '0;
    logic          m_err_s   = 1'b0;
    logic          m_err_p   = 1'b0;
    logic [W-1:0]  exp_q[$];

    always #5 clock = ~clock;

    kw_stream_credit_tx #(.DATA_WIDTH(W), .CREDITS(C), .ERR_MODE(1)) dut_sticky (
        .clock (clock), .reset (reset), .i_valid (i_valid), .i_ready (rdy_s), .i_data (i_data),
        .o_valid (ov_s), .o_data (od_s), .credit_ret (credit_ret), .credit_count (cnt_s),
        .err (err_s)
    );

    kw_stream_credit_tx #(.DATA_WIDTH(W), .CREDITS(C), .ERR_MODE(0)) dut_pulse (
        .clock (clock), .reset (reset), .i_valid (i_valid), .i_ready (rdy_p), .i_data (i_data),
        .o_valid (ov_p), .o_data (od_p), .credit_ret (credit_ret), .credit_count (cnt_p),
        .err (err_p)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: drive inputs, check i_ready, advance the model across the edge, check outputs.
    task automatic cycle(input logic v, input logic [W-1:0] d, input logic cr, input logic rst);
        logic acc;
        logic ovf;
        i_valid    = v;
        i_data     = d;
        credit_ret = cr;
        reset      = rst;
        #1;
        check("i_ready_sticky", 32'(rdy_s), 32'(!rst && m_credits != 0));
        check("i_ready_pulse",  32'(rdy_p), 32'(!rst && m_credits != 0));
        acc = v && !rst && (m_credits != 0);
        ovf = cr && !acc && (m_credits == C);
        @(posedge clock);
        if (rst) begin
            m_credits = C;
            m_valid   = 1'b0;
            m_data    = '0;
            m_err_s   = 1'b0;
            m_err_p   = 1'b0;
            exp_q.delete();
        end else begin
            m_credits = m_credits - int'(acc) + int'(cr);
            if (m_credits > C) m_credits = C;
            m_valid = acc;
            if (acc) begin
                m_data = d;
                exp_q.push_back(d);
            end
            m_err_p = ovf;
            m_err_s = m_err_s | ovf;
        end
        #1;
        check("o_valid_sticky", 32'(ov_s), 32'(m_valid));
        check("o_valid_pulse",  32'(ov_p), 32'(m_valid));
        check("o_data_sticky",  32'(od_s), 32'(m_data));
        check("o_data_pulse",   32'(od_p), 32'(m_data));
        check("count_sticky",   32'(cnt_s), 32'(m_credits));
        check("count_pulse",    32'(cnt_p), 32'(m_credits));
        check("err_sticky",     32'(err_s), 32'(m_err_s));
        check("err_pulse",      32'(err_p), 32'(m_err_p));
        if (ov_s) begin
            if (exp_q.size() == 0) check("beat_unexpected", 32'(od_s), 32'hFFFF_FFFF);
            else                   check("beat_order", 32'(od_s), 32'(exp_q.pop_front()));
        end
    endtask

    initial begin
        i_valid    = 1'b0;
        i_data     = '0;
        credit_ret = 1'b0;
        reset      = 1'b1;

        // Reset then idle: full credits, ready, nothing emitted
        cycle(0, 0, 0, 1);
        repeat (3) cycle(0, 0, 0, 0);
        check("idle_count", 32'(cnt_s), 32'd32);
        check("idle_ready", 32'(rdy_s), 32'd1);

        // Burst of 32 words exhausts credits; word 0x20 is held
        for (int i = 0; i < 32; i++) cycle(1, W'(i), 0, 0);
        check("burst_last_data", 32'(od_s), 32'h1F);
        repeat (3) cycle(1, 16'h0020, 0, 0);
        check("empty_count", 32'(cnt_s), 32'd0);
        check("empty_ready", 32'(rdy_s), 32'd0);
        check("held_not_sent", 32'(ov_s), 32'd0);

        // One credit back releases 0x0020, then count returns to 0
        cycle(1, 16'h0020, 1, 0);
        check("ret_ready", 32'(rdy_s), 32'd1);
        cycle(1, 16'h0020, 0, 0);
        check("ret_emit_data", 32'(od_s), 32'h20);
        check("ret_emit_count", 32'(cnt_s), 32'd0);

        // At count 1: accept plus simultaneous credit keeps count at 1
        cycle(0, 0, 1, 0);
        cycle(1, 16'h0055, 1, 0);
        check("c1_count", 32'(cnt_s), 32'd1);
        check("c1_ready", 32'(rdy_s), 32'd1);
        cycle(1, 16'h0056, 0, 0);
        check("c1_next_data", 32'(od_s), 32'h56);

        // Refill to 32 then overflow by one credit
        for (int i = 0; i < 32; i++) cycle(0, 0, 1, 0);
        check("full_count", 32'(cnt_s), 32'd32);
        cycle(0, 0, 1, 0);
        check("ovf_count", 32'(cnt_s), 32'd32);
        check("ovf_err_s", 32'(err_s), 32'd1);
        check("ovf_err_p", 32'(err_p), 32'd1);
        repeat (4) cycle(0, 0, 0, 0);
        check("ovf_err_s_held", 32'(err_s), 32'd1);
        check("ovf_err_p_gone", 32'(err_p), 32'd0);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 0);
        check("err_cleared", 32'(err_s), 32'd0);

        // Reset in the middle of a burst at count 10
        for (int i = 0; i < 22; i++) cycle(1, W'(16'h0100 + i), 0, 0);
        check("mid_count", 32'(cnt_s), 32'd10);
        check("mid_valid", 32'(ov_s), 32'd1);
        cycle(1, 16'h0200, 0, 1);
        check("rst_valid", 32'(ov_s), 32'd0);
        check("rst_data", 32'(od_s), 32'd0);
        check("rst_count", 32'(cnt_s), 32'd32);
        check("rst_err", 32'(err_s), 32'd0);

        // Random traffic with credit returns, rare overflows and rare resets
        for (int i = 0; i < 3000; i++) begin
            logic v, cr, rst;
            v   = ($urandom_range(0, 99) < 70);
            cr  = (m_credits < C) ? ($urandom_range(0, 99) < 60) : ($urandom_range(0, 99) < 3);
            rst = ($urandom_range(0, 999) < 4);
            cycle(v, W'($urandom), cr, rst);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
